// File: rtl/zap_btb_pkg.sv
// ============================================================================
// zap_btb_pkg : branch-state encodings, entry layout and 2-bit counter update
// Revision 1.0
// ============================================================================
`default_nettype none

package zap_btb_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Widest tag any legal geometry needs (index is always at least one bit).
    localparam int MAX_TAG_W = 30;

    typedef struct packed {
        logic [31:0]          target;
        logic [MAX_TAG_W-1:0] tag;
        logic [1:0]           state;
    } btb_entry_t;

    function automatic logic [1:0] compute(input logic [1:0] state, input logic nok);
        logic taken;
        taken = (state >= WT) ^ nok;
        if (taken)
            return (state == ST) ? ST : state + 2'd1;
        else
            return (state == SNT) ? SNT : state - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zap_ram_simple_nopipe.sv
// ============================================================================
// zap_ram_simple_nopipe : 1W/1R RAM, registered read-before-write, read enable
// Revision 1.0
// ============================================================================
`default_nettype none

module zap_ram_simple_nopipe #(
    parameter  int DEPTH  = 32,
    parameter  int WIDTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            o_rd_data <= mem[i_rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/zap_btb_assoc.sv
// ============================================================================
// zap_btb_assoc : set-associative branch target buffer, round-robin victims
// Revision 1.0
// ============================================================================
`default_nettype none

module zap_btb_assoc
    import zap_btb_pkg::*;
#(
    parameter  int BP_ENTRIES = 1024,
    parameter  int WAYS       = 2,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_clear,
    input  logic             i_fb_ok,
    input  logic             i_fb_nok,
    input  logic             i_fb_hit,
    input  logic [WAY_W-1:0] i_fb_way,
    input  logic [31:0]      i_fb_branch_src_address,
    input  logic [1:0]       i_fb_current_branch_state,
    input  logic [31:0]      i_fb_branch_dest_address,
    input  logic [31:0]      i_rd_addr,
    input  logic [31:0]      i_rd_addr_del,
    output logic             o_clear_from_btb,
    output logic [31:0]      o_pc_from_btb,
    output logic             o_btb_hit,
    output logic [WAY_W-1:0] o_btb_hit_way
);

    localparam int SETS  = BP_ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 31 - IDX_W;
    localparam int ENT_W = 34 + TAG_W;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag_del;
    logic [TAG_W-1:0] wr_tag;

    logic             wr_en;
    logic [WAY_W-1:0] wr_way;
    logic [WAY_W-1:0] victim_next;
    btb_entry_t       wr_entry;
    logic [ENT_W-1:0] wr_word;

    logic [WAYS-1:0]  valid  [SETS];
    logic [WAY_W-1:0] victim [SETS];
    logic [WAYS-1:0]  rd_valid;
    logic [ENT_W-1:0] rd_data [WAYS];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [31:0]      hit_target;
    logic [1:0]       hit_state;

    logic             unused_bits;

    assign rd_idx     = i_rd_addr[IDX_W:1];
    assign rd_tag_del = i_rd_addr_del[31:IDX_W+1];
    assign wr_idx     = i_fb_branch_src_address[IDX_W:1];
    assign wr_tag     = i_fb_branch_src_address[31:IDX_W+1];

    assign unused_bits = ^{i_rd_addr[31:IDX_W+1], i_rd_addr[0],
                           i_rd_addr_del[IDX_W:0], i_fb_branch_src_address[0]};

    // A flush swallows any feedback write arriving in the same cycle.
    assign wr_en       = (i_fb_ok | i_fb_nok) & ~i_clear & ~i_reset;
    assign wr_way      = i_fb_hit ? i_fb_way : victim[wr_idx];
    assign victim_next = (victim[wr_idx] == WAY_W'(WAYS - 1)) ? '0
                                                               : victim[wr_idx] + 1'b1;

    always_comb begin
        wr_entry        = '0;
        wr_entry.target = i_fb_branch_dest_address;
        wr_entry.tag    = MAX_TAG_W'(wr_tag);
        wr_entry.state  = compute(i_fb_current_branch_state, i_fb_nok);
        wr_word         = {wr_entry.target, wr_entry.tag[TAG_W-1:0], wr_entry.state};
    end

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            zap_ram_simple_nopipe #(
                .DEPTH (SETS),
                .WIDTH (ENT_W)
            ) u_ram (
                .i_clk     (i_clk),
                .i_wr_en   (wr_en && (wr_way == WAY_W'(g))),
                .i_wr_addr (wr_idx),
                .i_wr_data (wr_word),
                .i_rd_en   (~i_stall),
                .i_rd_addr (rd_idx),
                .o_rd_data (rd_data[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                victim[s] <= '0;
            end
        end else if (wr_en) begin
            for (int w = 0; w < WAYS; w++)
                if (wr_way == WAY_W'(w))
                    valid[wr_idx][w] <= 1'b1;
            if (!i_fb_hit)
                victim[wr_idx] <= victim_next;
        end
    end

    // Descending scan so the lowest-numbered matching way is the last assignment.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        hit_target = '0;
        hit_state  = SNT;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_data[w][TAG_W+1:2] == rd_tag_del)) begin
                hit        = 1'b1;
                hit_way    = WAY_W'(w);
                hit_target = rd_data[w][ENT_W-1:TAG_W+2];
                hit_state  = rd_data[w][1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_valid         <= '0;
            o_btb_hit        <= 1'b0;
            o_btb_hit_way    <= '0;
            o_clear_from_btb <= 1'b0;
            o_pc_from_btb    <= '0;
        end else if (i_clear) begin
            rd_valid         <= '0;
            o_btb_hit        <= 1'b0;
            o_btb_hit_way    <= '0;
            o_clear_from_btb <= 1'b0;
        end else if (!i_stall) begin
            rd_valid         <= valid[rd_idx];
            o_btb_hit        <= hit;
            o_btb_hit_way    <= hit_way;
            o_clear_from_btb <= hit & hit_state[1];
            if (hit && hit_state[1])
                o_pc_from_btb <= hit_target;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zap_btb_assoc.sv
// ============================================================================
// tb_zap_btb_assoc : directed self-checking bench, 8 entries / 2 ways
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_zap_btb_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        clr = 1'b0;
    logic        fb_ok = 1'b0;
    logic        fb_nok = 1'b0;
    logic        fb_hit = 1'b0;
    logic [0:0]  fb_way = 1'b0;
    logic [31:0] fb_src = '0;
    logic [1:0]  fb_state = '0;
    logic [31:0] fb_dest = '0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_addr_del = '0;
    logic [31:0] last_addr = '0;

    logic        clear_from_btb;
    logic [31:0] pc_from_btb;
    logic        btb_hit;
    logic [0:0]  btb_hit_way;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    zap_btb_assoc #(
        .BP_ENTRIES (8),
        .WAYS       (2)
    ) dut (
        .i_clk                     (clk),
        .i_reset                   (rst),
        .i_stall                   (stall),
        .i_clear                   (clr),
        .i_fb_ok                   (fb_ok),
        .i_fb_nok                  (fb_nok),
        .i_fb_hit                  (fb_hit),
        .i_fb_way                  (fb_way),
        .i_fb_branch_src_address   (fb_src),
        .i_fb_current_branch_state (fb_state),
        .i_fb_branch_dest_address  (fb_dest),
        .i_rd_addr                 (rd_addr),
        .i_rd_addr_del             (rd_addr_del),
        .o_clear_from_btb          (clear_from_btb),
        .o_pc_from_btb             (pc_from_btb),
        .o_btb_hit                 (btb_hit),
        .o_btb_hit_way             (btb_hit_way)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One un-stalled fetch cycle: the delayed address follows the previous fetch.
    task automatic present(input logic [31:0] addr);
        rd_addr_del = last_addr;
        last_addr   = addr;
        rd_addr     = addr;
        cyc();
    endtask

    // Outputs reflect addr once this returns.
    task automatic read(input logic [31:0] addr);
        present(addr);
        present(32'h0);
    endtask

    task automatic fb(input logic ok, input logic nok, input logic hit, input logic way,
                      input logic [31:0] src, input logic [1:0] st, input logic [31:0] dst);
        fb_ok = ok; fb_nok = nok; fb_hit = hit; fb_way = way;
        fb_src = src; fb_state = st; fb_dest = dst;
        cyc();
        fb_ok = 1'b0; fb_nok = 1'b0; fb_hit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (btb_hit !== 1'b0 || clear_from_btb !== 1'b0 || btb_hit_way !== 1'b0 || pc_from_btb !== 32'h0) begin
            failed++;
            $display("FAIL reset_outputs: hit=%b clr=%b way=%b pc=%h, want all 0", btb_hit, clear_from_btb, btb_hit_way, pc_from_btb);
        end
        for (int i = 0; i < 10; i++) begin
            present(32'h100);
            tests++;
            if (btb_hit !== 1'b0 || clear_from_btb !== 1'b0) begin
                failed++;
                $display("FAIL reset_cold_read[%0d]: hit=%b clr=%b, want 0 0", i, btb_hit, clear_from_btb);
            end
        end
    endtask

    task automatic test_alloc_nok();
        fb(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 2'd1, 32'h200);
        read(32'h100);
        tests++;
        if (btb_hit !== 1'b1 || clear_from_btb !== 1'b1 || pc_from_btb !== 32'h200 || btb_hit_way !== 1'b0) begin
            failed++;
            $display("FAIL alloc_nok: hit=%b clr=%b pc=%h way=%b, want 1 1 00000200 0", btb_hit, clear_from_btb, pc_from_btb, btb_hit_way);
        end
    endtask

    task automatic test_evict();
        do_reset();
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 2'd2, 32'h1000);
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 2'd2, 32'h1008);
        read(32'h108);
        tests++;
        if (btb_hit !== 1'b1 || btb_hit_way !== 1'b1 || pc_from_btb !== 32'h1008) begin
            failed++;
            $display("FAIL evict_second_way: hit=%b way=%b pc=%h, want 1 1 00001008", btb_hit, btb_hit_way, pc_from_btb);
        end
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h110, 2'd2, 32'h1010);
        read(32'h100);
        tests++;
        if (btb_hit !== 1'b0 || clear_from_btb !== 1'b0) begin
            failed++;
            $display("FAIL evict_victim_gone: hit=%b clr=%b, want 0 0", btb_hit, clear_from_btb);
        end
        read(32'h108);
        tests++;
        if (btb_hit !== 1'b1 || btb_hit_way !== 1'b1 || clear_from_btb !== 1'b1 || pc_from_btb !== 32'h1008) begin
            failed++;
            $display("FAIL evict_survivor: hit=%b way=%b clr=%b pc=%h, want 1 1 1 00001008", btb_hit, btb_hit_way, clear_from_btb, pc_from_btb);
        end
        read(32'h110);
        tests++;
        if (btb_hit !== 1'b1 || btb_hit_way !== 1'b0 || pc_from_btb !== 32'h1010) begin
            failed++;
            $display("FAIL evict_new_entry: hit=%b way=%b pc=%h, want 1 0 00001010", btb_hit, btb_hit_way, pc_from_btb);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 2'd3, 32'h300);
        fb(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 2'd3, 32'h300);
        read(32'h100);
        tests++;
        if (btb_hit !== 1'b1 || clear_from_btb !== 1'b1 || pc_from_btb !== 32'h300) begin
            failed++;
            $display("FAIL sat_strong: hit=%b clr=%b pc=%h, want 1 1 00000300", btb_hit, clear_from_btb, pc_from_btb);
        end
        fb(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 2'd3, 32'h300);
        fb(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 2'd2, 32'h300);
        read(32'h100);
        tests++;
        if (btb_hit !== 1'b1 || clear_from_btb !== 1'b0 || btb_hit_way !== 1'b0 || pc_from_btb !== 32'h300) begin
            failed++;
            $display("FAIL sat_down_to_wnt: hit=%b clr=%b way=%b pc=%h, want 1 0 0 00000300", btb_hit, clear_from_btb, btb_hit_way, pc_from_btb);
        end
        // ok and nok together act as nok: WNT mispredicted-not-taken moves up to WT.
        fb(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 2'd1, 32'h340);
        read(32'h100);
        tests++;
        if (btb_hit !== 1'b1 || clear_from_btb !== 1'b1 || pc_from_btb !== 32'h340) begin
            failed++;
            $display("FAIL ok_nok_both: hit=%b clr=%b pc=%h, want 1 1 00000340", btb_hit, clear_from_btb, pc_from_btb);
        end
    endtask

    task automatic test_clear();
        present(32'h100);
        present(32'h100);
        tests++;
        if (clear_from_btb !== 1'b1) begin
            failed++;
            $display("FAIL clear_pre: clr=%b, want 1", clear_from_btb);
        end
        clr = 1'b1;
        fb_ok = 1'b1; fb_hit = 1'b0; fb_src = 32'h108; fb_state = 2'd3; fb_dest = 32'h800;
        present(32'h100);
        clr = 1'b0; fb_ok = 1'b0;
        tests++;
        if (clear_from_btb !== 1'b0 || btb_hit !== 1'b0) begin
            failed++;
            $display("FAIL clear_next_cycle: clr=%b hit=%b, want 0 0", clear_from_btb, btb_hit);
        end
        read(32'h100);
        tests++;
        if (btb_hit !== 1'b0) begin
            failed++;
            $display("FAIL clear_old_entry: hit=%b, want 0", btb_hit);
        end
        read(32'h108);
        tests++;
        if (btb_hit !== 1'b0) begin
            failed++;
            $display("FAIL clear_dropped_write: hit=%b, want 0", btb_hit);
        end
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h118, 2'd3, 32'h900);
        read(32'h118);
        tests++;
        if (btb_hit !== 1'b1 || btb_hit_way !== 1'b0 || pc_from_btb !== 32'h900) begin
            failed++;
            $display("FAIL clear_victim_restart: hit=%b way=%b pc=%h, want 1 0 00000900", btb_hit, btb_hit_way, pc_from_btb);
        end
    endtask

    task automatic test_stall();
        do_reset();
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 2'd3, 32'h400);
        fb(1'b1, 1'b0, 1'b0, 1'b0, 32'h102, 2'd3, 32'h500);
        present(32'h100);
        present(32'h102);
        tests++;
        if (btb_hit !== 1'b1 || pc_from_btb !== 32'h400) begin
            failed++;
            $display("FAIL stall_before: hit=%b pc=%h, want 1 00000400", btb_hit, pc_from_btb);
        end
        // A stray fetch address during stall must not disturb the held read.
        stall = 1'b1;
        rd_addr = 32'h110;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if (btb_hit !== 1'b1 || clear_from_btb !== 1'b1 || pc_from_btb !== 32'h400) begin
                failed++;
                $display("FAIL stall_frozen[%0d]: hit=%b clr=%b pc=%h, want 1 1 00000400", i, btb_hit, clear_from_btb, pc_from_btb);
            end
        end
        stall = 1'b0;
        present(32'h100);
        tests++;
        if (btb_hit !== 1'b1 || btb_hit_way !== 1'b0 || clear_from_btb !== 1'b1 || pc_from_btb !== 32'h500) begin
            failed++;
            $display("FAIL stall_resume: hit=%b way=%b clr=%b pc=%h, want 1 0 1 00000500", btb_hit, btb_hit_way, clear_from_btb, pc_from_btb);
        end
        present(32'h0);
        tests++;
        if (btb_hit !== 1'b1 || pc_from_btb !== 32'h400) begin
            failed++;
            $display("FAIL stall_next: hit=%b pc=%h, want 1 00000400", btb_hit, pc_from_btb);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_nok();
        test_evict();
        test_saturate();
        test_clear();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/zap_btb_assoc.md
ZAP_BTB_ASSOC -- requirements
Module: zap_btb_assoc

Interface
REQ-001 Parameter BP_ENTRIES, default 1024: total BTB entries; power of two.
REQ-002 Parameter WAYS, default 2: associativity; power of two, range 1..8, BP_ENTRIES/WAYS >= 2.
REQ-003 Derived constants: SETS = BP_ENTRIES/WAYS; IDX_W = clog2(SETS); WAY_W = max(1, clog2(WAYS)); TAG_W = 31 - IDX_W.
REQ-004 i_clk  in  1  clock; all logic is rising-edge.
REQ-005 i_reset  in  1  reset; synchronous, active-high.
REQ-006 i_stall  in  1  pipeline stall; freezes the read path.
REQ-007 i_clear  in  1  flush; invalidates all entries.
REQ-008 i_fb_ok  in  1  feedback: prediction was correct.
REQ-009 i_fb_nok  in  1  feedback: prediction was wrong.
REQ-010 i_fb_hit  in  1  feedback branch hit in the BTB when it was fetched.
REQ-011 i_fb_way  in  WAY_W  way that hit at fetch; valid only when i_fb_hit=1.
REQ-012 i_fb_branch_src_address  in  32  branch source address.
REQ-013 i_fb_current_branch_state  in  2  predicted 2-bit state carried down the pipeline.
REQ-014 i_fb_branch_dest_address  in  32  resolved branch target.
REQ-015 i_rd_addr  in  32  fetch address, presented this cycle.
REQ-016 i_rd_addr_del  in  32  i_rd_addr delayed by one un-stalled cycle.
REQ-017 o_clear_from_btb  out  1  redirect fetch to o_pc_from_btb.
REQ-018 o_pc_from_btb  out  32  predicted target.
REQ-019 o_btb_hit  out  1  tag hit, regardless of direction.
REQ-020 o_btb_hit_way  out  WAY_W  way that hit; the pipeline returns it as i_fb_way.

Function
REQ-021 Address breakup: bit 0 is the offset and is ignored; bits [IDX_W:1] are the set index; bits [31:IDX_W+1] are the tag.
REQ-022 Each way entry SHALL hold {target[31:0], tag[TAG_W-1:0], state[1:0]}; each way/set also has a valid flop and each set has a WAY_W round-robin victim pointer.
REQ-023 When i_stall=0, all ways SHALL be read at i_rd_addr.index, and per-way valid bits SHALL be sampled in the same edge.
REQ-024 Hit in the next cycle: way w hits when its valid bit is 1 and its tag equals i_rd_addr_del.tag; if more than one way hits, the lowest-numbered way wins.
REQ-025 Registered outputs, updated only when i_stall=0:
- o_btb_hit = hit.
- o_btb_hit_way = winning way, or 0 on a miss.
- o_clear_from_btb = hit & state in {WT, ST}.
- o_pc_from_btb = winning target when o_clear is set; otherwise held.
REQ-026 Latency: address at edge N gives outputs valid after edge N+2, counting un-stalled edges only.
REQ-027 When i_stall=1, all outputs and read registers SHALL hold their values.
REQ-028 A write occurs when (i_fb_ok | i_fb_nok) = 1; if both are high, the write SHALL be treated as nok.
REQ-029 Write way selection:
- i_fb_hit=1: write i_fb_way.
- i_fb_hit=0: write the set's victim pointer, and advance the pointer by 1 modulo WAYS.
REQ-030 Write data: tag from the source address; target = i_fb_branch_dest_address; state = compute(i_fb_current_branch_state, nok); the written way's valid bit is set to 1.
REQ-031 compute, with SNT=0, WNT=1, WT=2, ST=3:
- Branch taken means (state>=WT) XOR nok.
- Taken increments the state, saturating at ST; not-taken decrements it, saturating at SNT.
REQ-032 Valid bits SHALL only be set by writes; a cycle without a write SHALL leave all valid bits unchanged.
REQ-033 A read and a write to the same set in the same edge: the read SHALL return pre-write data and pre-write valid bits, with no forwarding.
REQ-034 When i_clear=1: all valid bits and victim pointers are cleared and o_clear_from_btb is 0 next cycle; a simultaneous feedback write is discarded.

Reset
REQ-035 i_reset=1 SHALL clear all valid bits, all victim pointers, and the read-path valid register; all outputs go to 0. Reset has priority over i_clear and i_stall.
REQ-036 RAM contents are not reset; correctness relies on the valid bits alone.

Structure
REQ-037 Package zap_btb_pkg SHALL hold the SNT/WNT/WT/ST encodings, the compute function, and the entry struct typedef.
REQ-038 Storage: one zap_ram_simple_nopipe instance per way (DEPTH=SETS, WIDTH=34+TAG_W), generated in a loop; valid bits and victim pointers are flops.

Verification
All scenarios use BP_ENTRIES=8, WAYS=2 (index = addr[2:1]).
REQ-039 Reset, then read 0x100 for 10 cycles -> o_clear_from_btb and o_btb_hit stay 0.
REQ-040 fb_nok, hit=0, src 0x100, dest 0x200, state WNT -> way0 written with state WT; then read 0x100 -> 2 cycles later o_clear=1, o_pc=0x200, o_hit_way=0.
REQ-041 Allocate src 0x100, then 0x108, then 0x110 (all set 0, all taken):
- 0x108 -> way1.
- 0x110 evicts way0; read 0x100 -> o_btb_hit=0; read 0x108 -> hit, way 1.
REQ-042 Entry in ST, then fb_ok with state ST -> stays ST; then fb_nok, hit=1, way 0, twice -> state becomes WNT; read -> o_btb_hit=1, o_clear=0.
REQ-043 Programmed entry, pulse i_clear together with a feedback write -> subsequent reads give o_btb_hit=0; the victim pointer restarts at way0.
REQ-044 Hit pending, i_stall=1 for 3 cycles -> outputs frozen; release -> pipeline resumes with no lost or duplicated prediction.
